// File: rtl/mips_pkg.sv
// Shared datapath definitions for the single-cycle MIPS core.
// Word width and the word type used by datapath muxes and registers.
package mips_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

endpackage : mips_pkg

// File: rtl/mux_21_cell.sv
// Purely combinational WIDTH-bit 2:1 word select.
// The ?: operator merges a and b bitwise when sel is X/Z, so unknown select never picks a side.
module mux_21_cell
  import mips_pkg::*;
#(
  parameter int WIDTH = WORD_W
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  output logic [WIDTH-1:0] out
);

  assign out = sel ? b : a;

endmodule : mux_21_cell

// File: rtl/mux_21.sv
// Datapath word mux: zero-latency combinational out plus a registered out_q tap.
// Reset is synchronous active-low and touches only the registered copy.
module mux_21
  import mips_pkg::*;
#(
  parameter int               WIDTH     = WORD_W,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_q
);

  logic [WIDTH-1:0] w_sel_word;
  logic [WIDTH-1:0] r_out_q;

  mux_21_cell #(
    .WIDTH (WIDTH)
  ) u_cell (
    .a   (a),
    .b   (b),
    .sel (sel),
    .out (w_sel_word)
  );

  assign out = w_sel_word;

  // Registered tap captures the same selected word one clock later.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_q <= RESET_VAL;
    end else begin
      r_out_q <= w_sel_word;
    end
  end

  assign out_q = r_out_q;

endmodule : mux_21

// File: tb/tb_mux_21.sv
// Directed self-checking bench for mux_21: combinational select, boundary words,
// tied-off clock/reset instance, and the registered out_q path through reset.
module tb_mux_21;

  localparam int W = 32;

  logic          clk;
  logic          rst_n;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          sel;
  logic [W-1:0]  out;
  logic [W-1:0]  out_q;
  logic [W-1:0]  out_tied;
  logic [W-1:0]  out_q_tied;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_w;

  mux_21 #(.WIDTH(W), .RESET_VAL('0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .b     (b),
    .sel   (sel),
    .out   (out),
    .out_q (out_q)
  );

  // Second instance with clock and reset tied off; only the combinational path is used.
  mux_21 #(.WIDTH(W), .RESET_VAL('0)) dut_tied (
    .clk   (1'b0),
    .rst_n (1'b1),
    .a     (a),
    .b     (b),
    .sel   (sel),
    .out   (out_tied),
    .out_q (out_q_tied)
  );

  // Clock / reset block.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Driver task.
  task automatic drive(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vs);
    a   = va;
    b   = vb;
    sel = vs;
  endtask

  // Scoreboard comparison.
  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  initial begin
    rst_n = 1'b1;
    drive('0, '0, 1'b0);

    // Combinational path, checked 1 ns after each input change.
    drive(32'h12345678, 32'hABCDEF00, 1'b0);
    #1;
    check("comb_sel0", out, 32'h12345678);
    check("tied_sel0", out_tied, 32'h12345678);

    drive(32'h11111111, 32'h22222222, 1'b1);
    #1;
    check("comb_sel1", out, 32'h22222222);
    check("tied_sel1", out_tied, 32'h22222222);

    drive(32'h00000000, 32'hFFFFFFFF, 1'b0);
    #1;
    check("zeros_a", out, 32'h00000000);
    check("tied_zeros_a", out_tied, 32'h00000000);

    sel = 1'b1;
    #1;
    check("ones_b", out, 32'hFFFFFFFF);
    check("tied_ones_b", out_tied, 32'hFFFFFFFF);

    drive(32'hFFFFFFFF, 32'h00000000, 1'b1);
    #1;
    check("zeros_b", out, 32'h00000000);
    check("tied_zeros_b", out_tied, 32'h00000000);

    sel = 1'b0;
    #1;
    check("ones_a", out, 32'hFFFFFFFF);

    drive(32'h3C3C3C3C, 32'h3C3C3C3C, 1'b0);
    #1;
    check("same_sel0", out, 32'h3C3C3C3C);
    sel = 1'b1;
    #1;
    check("same_sel1", out, 32'h3C3C3C3C);

    // Registered path: reset held for two edges.
    @(negedge clk);
    rst_n = 1'b0;
    drive(32'hA5A5A5A5, 32'h5A5A5A5A, 1'b0);
    repeat (2) begin
      @(posedge clk);
      #1;
      check("rst_hold", out_q, 32'h00000000);
      check("rst_comb", out, 32'hA5A5A5A5);
    end

    // Release, sel toggles each cycle; out_q follows the prior cycle's out.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      rst_n = 1'b1;
      sel   = ~sel;
      exp_w = sel ? 32'h5A5A5A5A : 32'hA5A5A5A5;
      exp_q.push_back(exp_w);
      #1;
      check("run_comb", out, exp_w);
      @(posedge clk);
      #1;
      check("run_q", out_q, exp_q.pop_front());
    end

    // Single-edge reset mid-operation.
    @(negedge clk);
    rst_n = 1'b0;
    sel   = ~sel;
    exp_w = sel ? 32'h5A5A5A5A : 32'hA5A5A5A5;
    @(posedge clk);
    #1;
    check("mid_rst_q", out_q, 32'h00000000);
    check("mid_rst_comb", out, exp_w);

    // Tracking resumes on the first edge with reset released.
    @(negedge clk);
    rst_n = 1'b1;
    sel   = ~sel;
    exp_w = sel ? 32'h5A5A5A5A : 32'hA5A5A5A5;
    exp_q.push_back(exp_w);
    @(posedge clk);
    #1;
    check("resume_q", out_q, exp_q.pop_front());

    // Boundary words through the register.
    @(negedge clk);
    drive(32'hFFFFFFFF, 32'h00000000, 1'b0);
    @(posedge clk);
    #1;
    check("reg_ones", out_q, 32'hFFFFFFFF);
    @(negedge clk);
    sel = 1'b1;
    @(posedge clk);
    #1;
    check("reg_zeros", out_q, 32'h00000000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_mux_21
